// File: rtl/softmc_instr_receiver_if.sv
// Instruction path bundle: app_* from the PCIe application block, exec_* to the sequencer.
// The slave modport is the receiver's view; master is the surrounding logic's view.
interface softmc_instr_receiver_if #(
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   app_en;
    logic                   app_ack;
    logic [INSTR_WIDTH-1:0] app_instr;
    logic                   exec_valid;
    logic                   exec_ready;
    logic [INSTR_WIDTH-1:0] exec_instr;

    modport master (
        output app_en,
        output app_instr,
        output exec_ready,
        input  app_ack,
        input  exec_valid,
        input  exec_instr
    );

    modport slave (
        input  app_en,
        input  app_instr,
        input  exec_ready,
        output app_ack,
        output exec_valid,
        output exec_instr
    );
endinterface

// File: rtl/softmc_instr_receiver.sv
// Buffers a batch of SoftMC instructions until END (or a full FIFO), then streams the batch
// to the sequencer over valid/ready. Two-state LOAD/EXEC controller around a simple FIFO.
module softmc_instr_receiver #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned FIFO_AW     = 10,
    parameter logic [3:0]  END_OPC     = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    softmc_instr_receiver_if.slave bus,
    output logic                   exec_busy,
    output logic                   batch_done,
    output logic                   batch_split,
    output logic [FIFO_AW:0]       instr_count
);

    localparam int unsigned Depth = 1 << FIFO_AW;

    typedef enum logic {
        StLoad,
        StExec
    } state_e;

    state_e                 state_q;
    logic [FIFO_AW-1:0]     wr_ptr_q;
    logic [FIFO_AW-1:0]     rd_ptr_q;
    logic [FIFO_AW:0]       count_q;
    logic                   exec_valid_q;
    logic [INSTR_WIDTH-1:0] exec_instr_q;
    logic                   batch_done_q;
    logic                   batch_split_q;

    logic [INSTR_WIDTH-1:0] mem [Depth];

    logic in_load;
    logic is_end;
    logic full;
    logic empty;
    logic app_ack;
    logic wr_en;
    logic take_end;
    logic overflow;
    logic out_free;
    logic rd_en;
    logic exec_exit;

    always_comb begin
        in_load   = (state_q == StLoad);
        is_end    = (bus.app_instr[INSTR_WIDTH-1 -: 4] == END_OPC);
        // Occupancy never exceeds Depth, so the MSB alone flags a full FIFO.
        full      = count_q[FIFO_AW];
        empty     = (count_q == '0);
        app_ack   = rst_n & bus.app_en & in_load & ~(full & ~is_end);
        wr_en     = app_ack & ~is_end;
        take_end  = app_ack & is_end;
        overflow  = in_load & bus.app_en & full & ~is_end;
        out_free  = ~exec_valid_q | bus.exec_ready;
        rd_en     = ~in_load & out_free & ~empty;
        exec_exit = ~in_load & out_free & empty;
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.app_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StLoad;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            exec_valid_q  <= 1'b0;
            exec_instr_q  <= '0;
            batch_done_q  <= 1'b0;
            batch_split_q <= 1'b0;
        end else begin
            batch_done_q <= 1'b0;
            unique case (state_q)
                StLoad: begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        count_q  <= count_q + 1'b1;
                    end
                    if (take_end) begin
                        state_q <= StExec;
                    end else if (overflow) begin
                        // Stalled word stays on app_instr and is taken after this flush.
                        state_q       <= StExec;
                        batch_split_q <= 1'b1;
                    end
                end
                StExec: begin
                    if (rd_en) begin
                        exec_instr_q <= mem[rd_ptr_q];
                        exec_valid_q <= 1'b1;
                        rd_ptr_q     <= rd_ptr_q + 1'b1;
                        count_q      <= count_q - 1'b1;
                    end else if (exec_exit) begin
                        exec_valid_q <= 1'b0;
                        state_q      <= StLoad;
                        batch_done_q <= 1'b1;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign bus.app_ack    = app_ack;
    assign bus.exec_valid = exec_valid_q;
    assign bus.exec_instr = exec_instr_q;
    assign exec_busy      = (state_q == StExec);
    assign batch_done     = batch_done_q;
    assign batch_split    = batch_split_q;
    assign instr_count    = count_q;

endmodule

// File: tb/tb_softmc_instr_receiver.sv
// Bench for softmc_instr_receiver with a 4-deep FIFO: cycle table, directed corner
// sequences, and randomized batches checked against a batch-level scoreboard.
module tb_softmc_instr_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       exec_busy;
    logic       batch_done;
    logic       batch_split;
    logic [2:0] instr_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] tx_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] rx_q[$];

    typedef struct packed {
        logic        en;
        logic [31:0] instr;
        logic        rdy;
        logic        ack;
        logic        valid;
        logic [31:0] xinstr;
        logic        busy;
        logic        done;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[17];

    softmc_instr_receiver_if #(.INSTR_WIDTH(32)) bus ();

    softmc_instr_receiver #(
        .INSTR_WIDTH(32),
        .FIFO_AW    (2),
        .END_OPC    (4'hF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .exec_busy  (exec_busy),
        .batch_done (batch_done),
        .batch_split(batch_split),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input string name, input logic [31:0] w);
        bus.app_en    = 1'b1;
        bus.app_instr = w;
        #1;
        check(name, 64'(bus.app_ack), 64'd1);
        step();
        bus.app_en = 1'b0;
    endtask

    // Drives tx_q into the DUT and collects everything the sequencer side accepts.
    // rdy_mode: 0..100 = percent chance of exec_ready, 200 = toggle starting at 0.
    task automatic run_traffic(input string name, input int exp_dones, input int rdy_mode,
                               input int gap_pct, input int budget);
        int   dones = 0;
        int   cyc = 0;
        int   stab_bad = 0;
        int   inv_bad = 0;
        logic tog = 1'b0;
        logic held_v = 1'b0;
        logic [31:0] held_w = '0;
        rx_q.delete();
        while (cyc < budget && !(tx_q.size() == 0 && dones == exp_dones)) begin
            bus.app_en    = (tx_q.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
            bus.app_instr = bus.app_en ? tx_q[0] : $urandom;
            if (rdy_mode == 200) begin
                bus.exec_ready = tog;
                tog = ~tog;
            end else begin
                bus.exec_ready = ($urandom_range(0, 99) < rdy_mode);
            end
            #1;
            if (held_v && bus.exec_valid && bus.exec_instr !== held_w) stab_bad++;
            if (bus.app_ack && exec_busy) inv_bad++;
            if (bus.exec_valid && !exec_busy) inv_bad++;
            if (instr_count > 3'd4) inv_bad++;
            if (bus.app_ack) void'(tx_q.pop_front());
            if (bus.exec_valid && bus.exec_ready) rx_q.push_back(bus.exec_instr);
            if (batch_done) dones++;
            held_v = bus.exec_valid & ~bus.exec_ready;
            held_w = bus.exec_instr;
            step();
            cyc++;
        end
        bus.app_en     = 1'b0;
        bus.exec_ready = 1'b1;
        check({name, ".in_time"}, 64'(cyc < budget), 64'd1);
        check({name, ".dones"}, 64'(dones), 64'(exp_dones));
        check({name, ".count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s.word%0d", name, i),
                  (i < rx_q.size()) ? 64'(rx_q[i]) : 64'hx, 64'(exp_q[i]));
        end
        check({name, ".held_stable"}, 64'(stab_bad), 64'd0);
        check({name, ".invariants"}, 64'(inv_bad), 64'd0);
    endtask

    initial begin
        int          n;
        int          len;
        int          flushes;
        logic        split_exp;
        logic [31:0] w;

        //            en  instr          rdy ack val xinstr         busy done cnt
        vecs[0]  = '{1'b1, 32'h10000001, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0};
        vecs[1]  = '{1'b1, 32'h10000002, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd1};
        vecs[2]  = '{1'b1, 32'h10000003, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd2};
        vecs[3]  = '{1'b1, 32'hF0000000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd3};
        vecs[4]  = '{1'b1, 32'h20000000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 3'd3};
        vecs[5]  = '{1'b1, 32'h20000000, 1'b1, 1'b0, 1'b1, 32'h10000001, 1'b1, 1'b0, 3'd2};
        vecs[6]  = '{1'b1, 32'h20000000, 1'b1, 1'b0, 1'b1, 32'h10000002, 1'b1, 1'b0, 3'd1};
        vecs[7]  = '{1'b1, 32'h20000000, 1'b1, 1'b0, 1'b1, 32'h10000003, 1'b1, 1'b0, 3'd0};
        vecs[8]  = '{1'b1, 32'h30000000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'd0};
        vecs[9]  = '{1'b1, 32'hF0000000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd1};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 3'd1};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h30000000, 1'b1, 1'b0, 3'd0};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 3'd0};
        vecs[13] = '{1'b1, 32'hF0000000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0};
        vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 3'd0};
        vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 3'd0};
        vecs[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0};

        // Reset held with app_en high.
        bus.app_en     = 1'b1;
        bus.app_instr  = 32'h10000001;
        bus.exec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst.ack", 64'(bus.app_ack), 64'd0);
        check("rst.valid", 64'(bus.exec_valid), 64'd0);
        check("rst.count", 64'(instr_count), 64'd0);
        check("rst.split", 64'(batch_split), 64'd0);
        check("rst.busy", 64'(exec_busy), 64'd0);
        rst_n      = 1'b1;
        bus.app_en = 1'b0;
        step();
        bus.app_en = 1'b1;
        #1;
        check("rst.ack_after_release", 64'(bus.app_ack), 64'd1);
        bus.app_en = 1'b0;
        step();

        // Cycle table: basic batch, immediate reuse after batch_done, empty batch.
        for (int i = 0; i < 17; i++) begin
            bus.app_en     = vecs[i].en;
            bus.app_instr  = vecs[i].instr;
            bus.exec_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d.ack", i), 64'(bus.app_ack), 64'(vecs[i].ack));
            check($sformatf("vec%0d.valid", i), 64'(bus.exec_valid), 64'(vecs[i].valid));
            if (vecs[i].valid)
                check($sformatf("vec%0d.instr", i), 64'(bus.exec_instr), 64'(vecs[i].xinstr));
            check($sformatf("vec%0d.busy", i), 64'(exec_busy), 64'(vecs[i].busy));
            check($sformatf("vec%0d.done", i), 64'(batch_done), 64'(vecs[i].done));
            check($sformatf("vec%0d.cnt", i), 64'(instr_count), 64'(vecs[i].cnt));
            check($sformatf("vec%0d.split", i), 64'(batch_split), 64'd0);
            step();
        end
        bus.app_en = 1'b0;

        // Back-pressure with exec_ready toggling.
        tx_q  = '{32'h10000001, 32'h10000002, 32'h10000003, 32'hF0000000};
        exp_q = '{32'h10000001, 32'h10000002, 32'h10000003};
        run_traffic("bp", 1, 200, 0, 100);

        // Overflow: fifth word stalls and forces a split flush.
        bus.exec_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_word($sformatf("ovf.ack%0d", i), 32'h40000000 + i);
        bus.app_en    = 1'b1;
        bus.app_instr = 32'h40000004;
        #1;
        check("ovf.stall_ack", 64'(bus.app_ack), 64'd0);
        check("ovf.full_count", 64'(instr_count), 64'd4);
        step();
        #1;
        check("ovf.busy", 64'(exec_busy), 64'd1);
        check("ovf.split", 64'(batch_split), 64'd1);
        tx_q  = '{32'h40000004, 32'hF0000000};
        exp_q = '{32'h40000000, 32'h40000001, 32'h40000002, 32'h40000003, 32'h40000004};
        run_traffic("ovf", 2, 100, 0, 100);
        check("ovf.split_sticky", 64'(batch_split), 64'd1);

        // Reset in the middle of EXEC.
        for (int i = 0; i < 4; i++) send_word($sformatf("mid.ack%0d", i), 32'h50000000 + i);
        send_word("mid.ack_end", 32'hF0000000);
        bus.exec_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            #1;
            if (bus.exec_valid && bus.exec_ready) n++;
            step();
        end
        check("mid.two_delivered", 64'(n), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mid.valid", 64'(bus.exec_valid), 64'd0);
        check("mid.count", 64'(instr_count), 64'd0);
        check("mid.busy", 64'(exec_busy), 64'd0);
        check("mid.split", 64'(batch_split), 64'd0);
        for (int c = 0; c < 2; c++) begin
            step();
            #1;
            check($sformatf("mid.no_done%0d", c), 64'(batch_done), 64'd0);
        end
        rst_n = 1'b1;
        step();
        #1;
        check("mid.no_done_release", 64'(batch_done), 64'd0);
        tx_q  = '{32'h60000001, 32'h60000002, 32'hF0000000};
        exp_q = '{32'h60000001, 32'h60000002};
        run_traffic("mid.after", 1, 100, 0, 100);

        // Random batches: output must equal input order; flush count from batch length.
        split_exp = 1'b0;
        for (int b = 0; b < 25; b++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 9))
                                              : int'($urandom_range(0, 4));
            tx_q.delete();
            exp_q.delete();
            for (int i = 0; i < len; i++) begin
                w = {4'($urandom_range(0, 14)), 28'($urandom)};
                tx_q.push_back(w);
                exp_q.push_back(w);
            end
            tx_q.push_back({4'hF, 28'($urandom)});
            flushes = (len == 0) ? 1 : (len + 3) / 4;
            if (len > 4) split_exp = 1'b1;
            run_traffic($sformatf("rnd%0d", b), flushes, int'($urandom_range(30, 100)),
                        int'($urandom_range(0, 40)), 400);
        end
        check("rnd.split", 64'(batch_split), 64'(split_exp));
        check("rnd.idle_count", 64'(instr_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/softmc_instr_receiver.md
Name: softmc_instr_receiver

Overview:
MC-side responder for the app_en/app_ack/app_instr instruction interface driven by the PCIe application block. It buffers a batch of 32-bit SoftMC instructions in an internal FIFO until an END instruction arrives. It then streams the batch to the instruction sequencer over a valid/ready interface with back-pressure. This is the consumer end of the host-to-MC instruction path.

Parameters:
INSTR_WIDTH, 32, instruction width; must equal the app_instr width.
FIFO_AW, 10, FIFO address width; depth = 2^FIFO_AW entries.
END_OPC, 4'hF, value of instr[INSTR_WIDTH-1 -: 4] that marks end-of-batch.

Ports:
clk  in  1  single clock for the block.
rst_n  in  1  asynchronous, active-low reset.
app_en  in  1  instruction valid from the PCIe application block.
app_ack  out  1  instruction accepted this cycle (combinational).
app_instr  in  INSTR_WIDTH  instruction word.
exec_valid  out  1  exec_instr is valid (registered).
exec_ready  in  1  sequencer accepts exec_instr.
exec_instr  out  INSTR_WIDTH  instruction to the sequencer (registered).
exec_busy  out  1  high while in EXEC.
batch_done  out  1  one-cycle pulse on the EXEC->LOAD transition.
batch_split  out  1  sticky; set on an auto-flush caused by a full FIFO.
instr_count  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = LOAD; FIFO pointers and count = 0.
  - exec_valid, exec_instr, batch_done, batch_split = 0.
  - app_ack = 0 while rst_n is low.
- States: LOAD, EXEC (2-state FSM).
- app_ack = app_en & (state==LOAD) & ~(full & ~is_end).
  - is_end = app_instr[top 4 bits]==END_OPC.
  - full = count==2^FIFO_AW.
- LOAD, app_ack & ~is_end: write app_instr to the FIFO; count+1 next cycle.
- LOAD, app_ack & is_end: END is consumed and not stored; next state EXEC.
- LOAD, app_en & full & ~is_end: app_ack=0 (stall); next state EXEC; batch_split <= 1. The stalled word is accepted after returning to LOAD.
- exec_valid is always 0 in LOAD; the FIFO is never read in LOAD.
- EXEC read condition: (~exec_valid | exec_ready) & count>0.
  - On a read: exec_instr <= head word and exec_valid <= 1 next cycle; count-1.
- EXEC, exec_valid & exec_ready & count==0: exec_valid <= 0.
- Latency:
  - END accepted at cycle N -> exec_busy=1 at N+1 -> first exec_valid at N+2.
  - With exec_ready held high, one instruction is delivered per cycle.
- exec_instr is stable while exec_valid & ~exec_ready.
- EXEC exit: count==0 & (~exec_valid | exec_ready).
  - Next cycle: state LOAD, batch_done=1 for one cycle.
  - app_ack can assert in that same cycle.
- Empty batch (END with count 0):
  - EXEC lasts exactly one cycle; batch_done at N+2; no exec_valid.
- FIFO pointers wrap modulo 2^FIFO_AW.
- No simultaneous read and write: writes occur only in LOAD, reads only in EXEC.
- instr_count reflects the registered count and excludes the exec_instr holding register.
- batch_split clears only on reset.
- Reset mid-EXEC: all batch contents are discarded, with no batch_done pulse.
- app_instr is ignored when app_en=0.
- FIFO storage may be block RAM with a 1-cycle read; no storage reset is required.

Test Plan:
1. Reset: hold rst_n=0 with app_en=1 -> app_ack=0, exec_valid=0, instr_count=0, batch_split=0. Release -> app_ack=1 next cycle.
2. Basic batch, exec_ready=1: send 0x10000001, 0x10000002, 0x10000003, then END 0xF0000000 at cycle N.
   - exec_instr = ...01/...02/...03 at N+2/N+3/N+4.
   - app_ack=0 during N+1..N+4; batch_done=1 at N+5; instr_count peaks at 3.
3. Back-pressure: same batch with exec_ready toggling 0,1,0,1 -> each word held until accepted; order preserved; no loss or duplication.
4. Overflow, FIFO_AW=2: send 5 non-END words -> 4 acked, 5th stalls, batch_split=1.
   - 4 words are executed; after batch_done the 5th is acked.
   - A subsequent END executes it alone.
5. Empty batch: END only at cycle N -> exec_busy=1 at N+1 only; batch_done at N+2; exec_valid never 1.
6. Reset mid-EXEC: assert rst_n=0 after the 2nd of 4 words is delivered -> exec_valid=0 immediately, instr_count=0, state LOAD, no batch_done. A new batch then runs normally.
